ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 16 +
 rtl/ram_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// Requester bus for ram_arbiter: one instance per port (CPU, DMA).
`default_nettype none

interface ram_arbiter_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ack;
    logic [7:0]  rdata;

    modport master (output req, we, addr, wdata, input  ack, rdata);
    modport slave  (input  req, we, addr, wdata, output ack, rdata);
endinterface

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port (CPU/DMA) arbiter onto a single synchronous RAM, IDLE/ADDR/DATA per access.
// Optional macro RAM_ARB_ROUND_ROBIN_EN: contention goes to the non-owner instead of fixed CPU priority.
`default_nettype none

module ram_arbiter (
    input  wire logic        wb_clk_i,
    input  wire logic        rst,
    ram_arbiter_if.slave     cpu,
    ram_arbiter_if.slave     dma,
    output logic [15:0]      ram_addr,
    output logic [7:0]       ram_wdata,
    output logic             ram_WEb,
    output logic             ram_enabled,
    input  wire logic [7:0]  ram_rdata,
    output logic             busy,
    output logic             owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      state;
    logic        oor;
    logic        cpu_elig;
    logic        dma_elig;
    logic        grant_dma;
    logic        grant_any;
    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata;
    logic        own_we;

    always_comb begin
        cpu_elig  = cpu.req & ~cpu.ack;
        dma_elig  = dma.req & ~dma.ack;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        grant_dma = dma_elig & (~cpu_elig | ~owner);
`else
        // CPU keeps the RAM while it requests, including its own ack cycle.
        grant_dma = dma_elig & ~cpu.req;
`endif
        grant_any = cpu_elig | grant_dma;
        sel_addr  = grant_dma ? dma.addr  : cpu.addr;
        sel_wdata = grant_dma ? dma.wdata : cpu.wdata;
        own_we    = owner ? dma.we : cpu.we;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b1;
            oor         <= 1'b0;
            cpu.ack     <= 1'b0;
            dma.ack     <= 1'b0;
            cpu.rdata   <= 8'h00;
            dma.rdata   <= 8'h00;
            ram_addr    <= 16'h0000;
            ram_wdata   <= 8'h00;
            ram_WEb     <= 1'b1;
            ram_enabled <= 1'b0;
        end else begin
            cpu.ack <= 1'b0;
            dma.ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state       <= ADDR;
                        owner       <= grant_dma;
                        ram_addr    <= sel_addr;
                        ram_wdata   <= sel_wdata;
                        oor         <= (sel_addr[15:12] != 4'h0);
                        ram_enabled <= (sel_addr[15:12] == 4'h0);
                        ram_WEb     <= 1'b1;
                    end
                end
                ADDR: begin
                    state   <= DATA;
                    ram_WEb <= ~own_we;
                end
                DATA: begin
                    state       <= IDLE;
                    ram_enabled <= 1'b0;
                    ram_WEb     <= 1'b1;
                    // ram_WEb low in DATA marks a write: rdata holds.
                    if (owner) begin
                        dma.ack <= 1'b1;
                        if (ram_WEb) dma.rdata <= oor ? 8'hFF : ram_rdata;
                    end else begin
                        cpu.ack <= 1'b1;
                        if (ram_WEb) cpu.rdata <= oor ? 8'hFF : ram_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
